// File: rtl/apb_arbiter2.sv
// Two-requester round-robin APB arbiter in front of a single APB completer.
// One full transfer per grant; downstream and response paths are registered.
module apb_arbiter2 #(
    parameter  int AWIDTH = 10,
    parameter  int DSIZE  = 2,
    localparam int DBYTES = 1 << DSIZE,
    localparam int DWIDTH = DBYTES * 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              s0_psel,
    input  logic              s0_penable,
    input  logic [2:0]        s0_pprot,
    input  logic              s0_pwrite,
    input  logic [AWIDTH-1:0] s0_paddr,
    input  logic [DBYTES-1:0] s0_pstrb,
    input  logic [DWIDTH-1:0] s0_pwdata,
    output logic [DWIDTH-1:0] s0_prdata,
    output logic              s0_pready,
    output logic              s0_pslverr,
    input  logic              s1_psel,
    input  logic              s1_penable,
    input  logic [2:0]        s1_pprot,
    input  logic              s1_pwrite,
    input  logic [AWIDTH-1:0] s1_paddr,
    input  logic [DBYTES-1:0] s1_pstrb,
    input  logic [DWIDTH-1:0] s1_pwdata,
    output logic [DWIDTH-1:0] s1_prdata,
    output logic              s1_pready,
    output logic              s1_pslverr,
    output logic              m_psel,
    output logic              m_penable,
    output logic [2:0]        m_pprot,
    output logic              m_pwrite,
    output logic [AWIDTH-1:0] m_paddr,
    output logic [DBYTES-1:0] m_pstrb,
    output logic [DWIDTH-1:0] m_pwdata,
    input  logic [DWIDTH-1:0] m_prdata,
    input  logic              m_pready,
    input  logic              m_pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last_grant;
    logic   r_grant;
    logic   w_any;
    logic   w_pick;

    // penable is not needed: psel alone marks a pending request in IDLE
    logic w_unused;
    assign w_unused = s0_penable ^ s1_penable;

    // Contention goes to the port that was not served last
    always_comb begin
        w_any  = s0_psel | s1_psel;
        w_pick = (s0_psel && s1_psel) ? ~r_last_grant : s1_psel;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (m_pready) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            m_psel       <= 1'b0;
            m_penable    <= 1'b0;
            m_pprot      <= '0;
            m_pwrite     <= 1'b0;
            m_paddr      <= '0;
            m_pstrb      <= '0;
            m_pwdata     <= '0;
            s0_prdata    <= '0;
            s0_pready    <= 1'b0;
            s0_pslverr   <= 1'b0;
            s1_prdata    <= '0;
            s1_pready    <= 1'b0;
            s1_pslverr   <= 1'b0;
        end else begin
            s0_pready  <= 1'b0;
            s0_pslverr <= 1'b0;
            s1_pready  <= 1'b0;
            s1_pslverr <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_pick;
                        m_psel   <= 1'b1;
                        m_pprot  <= w_pick ? s1_pprot  : s0_pprot;
                        m_pwrite <= w_pick ? s1_pwrite : s0_pwrite;
                        m_paddr  <= w_pick ? s1_paddr  : s0_paddr;
                        m_pstrb  <= w_pick ? s1_pstrb  : s0_pstrb;
                        m_pwdata <= w_pick ? s1_pwdata : s0_pwdata;
                    end
                end
                SETUP: m_penable <= 1'b1;
                ACCESS: begin
                    if (m_pready) begin
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        if (r_grant) begin
                            s1_prdata  <= m_prdata;
                            s1_pready  <= 1'b1;
                            s1_pslverr <= m_pslverr;
                        end else begin
                            s0_prdata  <= m_prdata;
                            s0_pready  <= 1'b1;
                            s0_pslverr <= m_pslverr;
                        end
                    end
                end
                DONE: r_last_grant <= r_grant;
                default: ;
            endcase
        end
    end

endmodule
